// File: rtl/cnn_pkg.sv
// Shared widths and FSM state type for the convolution scheduler.
package cnn_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned KER_TAPS = 9;
    localparam int unsigned RES_W    = 20;
    localparam int unsigned KER_W    = PIX_W * KER_TAPS;
    localparam int unsigned CONV_W   = 2 * KER_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/cnn_line_window.sv
// Two line buffers plus a 3x3 sliding window over a raster-scanned image.
// The window is presented combinationally together with the pixel that completes it.
module cnn_line_window
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pix_acc,
    input  logic [PIX_W-1:0] i_pix_data,
    output logic [KER_W-1:0] o_window,
    output logic             o_win_valid,
    output logic             o_last_pix
);

    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);
    localparam int unsigned ColBits = 3 * PIX_W;

    logic [ColW-1:0]    r_col;
    logic [RowW-1:0]    r_row;
    logic [PIX_W-1:0]   r_line0 [IMG_W];  // row r-2
    logic [PIX_W-1:0]   r_line1 [IMG_W];  // row r-1
    // Window columns c-2 and c-1, packed {top, mid, bottom}
    logic [ColBits-1:0] r_win_c0;
    logic [ColBits-1:0] r_win_c1;

    logic [PIX_W-1:0] w_top;
    logic [PIX_W-1:0] w_mid;
    logic             w_col_end;
    logic             w_row_end;

    assign w_top      = r_line0[r_col];
    assign w_mid      = r_line1[r_col];
    assign w_col_end  = (r_col == ColW'(IMG_W - 1));
    assign w_row_end  = (r_row == RowW'(IMG_H - 1));
    assign o_last_pix = w_col_end && w_row_end;
    // Column counter is cleared at each row start, so no window spans a row boundary
    assign o_win_valid = i_pix_acc && (r_row >= RowW'(2)) && (r_col >= ColW'(2));

    assign o_window = {r_win_c0[ColBits-1 -: PIX_W], r_win_c1[ColBits-1 -: PIX_W], w_top,
                       r_win_c0[2*PIX_W-1 -: PIX_W], r_win_c1[2*PIX_W-1 -: PIX_W], w_mid,
                       r_win_c0[PIX_W-1:0], r_win_c1[PIX_W-1:0], i_pix_data};

    // Raster position of the next pixel to arrive
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_pix_acc) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Pixel data path; stale contents are never used before being overwritten
    always_ff @(posedge i_clk) begin
        if (i_pix_acc) begin
            r_line0[r_col] <= r_line1[r_col];
            r_line1[r_col] <= i_pix_data;
            r_win_c0       <= r_win_c1;
            r_win_c1       <= {w_top, w_mid, i_pix_data};
        end
    end

endmodule

// File: rtl/cnn_conv_scheduler.sv
// Frame sequencer: latches a kernel, streams windows to the conv engine and
// forwards engine results with tlast on the final result of each frame.
module cnn_conv_scheduler
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic              i_aclk,
    input  logic              i_areset,
    input  logic [KER_W-1:0]  i_s_ker_tdata,
    input  logic              i_s_ker_tvalid,
    output logic              o_s_ker_tready,
    input  logic [PIX_W-1:0]  i_s_pix_tdata,
    input  logic              i_s_pix_tvalid,
    output logic              o_s_pix_tready,
    input  logic              i_s_pix_tlast,
    output logic [CONV_W-1:0] o_m_conv_tdata,
    output logic              o_m_conv_tvalid,
    input  logic              i_m_conv_tready,
    input  logic [RES_W-1:0]  i_s_res_tdata,
    input  logic              i_s_res_tvalid,
    output logic              o_s_res_tready,
    output logic [RES_W-1:0]  o_m_out_tdata,
    output logic              o_m_out_tvalid,
    input  logic              i_m_out_tready,
    output logic              o_m_out_tlast,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int unsigned NumWin  = (IMG_W - 2) * (IMG_H - 2);
    localparam int unsigned ResCntW = $clog2(NumWin + 1);

    state_e              r_state;
    logic [KER_W-1:0]    r_kernel;
    logic                r_kernel_loaded;
    logic                r_frame_err;
    logic [CONV_W-1:0]   r_conv_data;
    logic                r_conv_valid;
    logic [ResCntW-1:0]  r_res_cnt;

    logic               w_active;
    logic               w_ker_ready;
    logic               w_pix_ready;
    logic               w_ker_acc;
    logic               w_pix_acc;
    logic               w_out_acc;
    logic               w_res_last;
    logic [KER_W-1:0]   w_window;
    logic               w_win_valid;
    logic               w_last_pix;

    // Input readiness; a kernel beat wins over a pixel in IDLE
    always_comb begin
        w_ker_ready = 1'b0;
        w_pix_ready = 1'b0;
        if (!i_areset) begin
            unique case (r_state)
                StIdle: begin
                    w_ker_ready = 1'b1;
                    w_pix_ready = r_kernel_loaded && !i_s_ker_tvalid;
                end
                StRun:   w_pix_ready = !r_conv_valid || i_m_conv_tready;
                default: ;
            endcase
        end
    end

    assign w_active   = (r_state != StIdle);
    assign w_ker_acc  = i_s_ker_tvalid && w_ker_ready;
    assign w_pix_acc  = i_s_pix_tvalid && w_pix_ready;
    assign w_out_acc  = w_active && i_s_res_tvalid && i_m_out_tready;
    assign w_res_last = (r_res_cnt == ResCntW'(NumWin - 1));

    assign o_s_ker_tready  = w_ker_ready;
    assign o_s_pix_tready  = w_pix_ready;
    assign o_m_conv_tdata  = r_conv_data;
    assign o_m_conv_tvalid = r_conv_valid;
    assign o_s_res_tready  = w_active && i_m_out_tready;
    assign o_m_out_tdata   = i_s_res_tdata;
    assign o_m_out_tvalid  = w_active && i_s_res_tvalid;
    assign o_m_out_tlast   = w_active && w_res_last;
    assign o_busy          = w_active;
    assign o_frame_err     = r_frame_err;

    cnn_line_window #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_line_window (
        .i_clk       (i_aclk),
        .i_rst       (i_areset),
        .i_pix_acc   (w_pix_acc),
        .i_pix_data  (i_s_pix_tdata),
        .o_window    (w_window),
        .o_win_valid (w_win_valid),
        .o_last_pix  (w_last_pix)
    );

    // Frame FSM, kernel register and sticky tlast mismatch flag
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state         <= StIdle;
            r_kernel        <= '0;
            r_kernel_loaded <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_ker_acc) begin
                        r_kernel        <= i_s_ker_tdata;
                        r_kernel_loaded <= 1'b1;
                        r_frame_err     <= 1'b0;
                        r_state         <= StRun;
                    end else if (w_pix_acc) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (w_pix_acc && w_last_pix) r_state <= StDrain;
                end
                StDrain: begin
                    if (w_out_acc && w_res_last) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
            // Kernel and pixel acceptance are exclusive, so this never races the clear
            if (w_pix_acc && (i_s_pix_tlast != w_last_pix)) r_frame_err <= 1'b1;
        end
    end

    // Window beat register, held until the engine takes it
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_conv_data  <= '0;
            r_conv_valid <= 1'b0;
        end else if (w_win_valid) begin
            r_conv_data  <= {r_kernel, w_window};
            r_conv_valid <= 1'b1;
        end else if (i_m_conv_tready) begin
            r_conv_valid <= 1'b0;
        end
    end

    // Result counter locating the last result of the frame
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_res_cnt <= '0;
        end else if (w_out_acc) begin
            r_res_cnt <= w_res_last ? '0 : r_res_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn_conv_scheduler.sv
// Directed bench: a 3x3 instance and a 4x4 instance share the stimulus, with
// valids steered by sel. Expected window beats are queued per frame and popped
// as the DUT issues them; a small engine model returns results for the out path.
module tb_cnn_conv_scheduler;

    logic         aclk = 1'b0;
    logic         areset;
    logic [71:0]  ker_data;
    logic         ker_valid;
    logic [7:0]   pix_data;
    logic         pix_valid;
    logic         pix_last;
    logic         conv_ready;
    logic [19:0]  res_data;
    logic         res_valid;
    logic         out_ready;
    logic         sel;

    logic         ker_valid_g [2];
    logic         pix_valid_g [2];
    logic         res_valid_g [2];
    logic         ker_ready_v [2];
    logic         pix_ready_v [2];
    logic [143:0] conv_data_v [2];
    logic         conv_valid_v [2];
    logic         res_ready_v [2];
    logic [19:0]  out_data_v [2];
    logic         out_valid_v [2];
    logic         out_last_v [2];
    logic         busy_v [2];
    logic         err_v [2];

    logic         ker_ready, pix_ready, conv_valid, out_valid, out_last, busy, frame_err;
    logic [143:0] conv_data;
    logic [19:0]  out_data;

    always #5 aclk = ~aclk;

    assign ker_valid_g[0] = ker_valid && !sel;
    assign ker_valid_g[1] = ker_valid && sel;
    assign pix_valid_g[0] = pix_valid && !sel;
    assign pix_valid_g[1] = pix_valid && sel;
    assign res_valid_g[0] = res_valid && !sel;
    assign res_valid_g[1] = res_valid && sel;

    assign ker_ready  = ker_ready_v[sel];
    assign pix_ready  = pix_ready_v[sel];
    assign conv_data  = conv_data_v[sel];
    assign conv_valid = conv_valid_v[sel];
    assign out_data   = out_data_v[sel];
    assign out_valid  = out_valid_v[sel];
    assign out_last   = out_last_v[sel];
    assign busy       = busy_v[sel];
    assign frame_err  = err_v[sel];

    cnn_conv_scheduler #(.IMG_W(3), .IMG_H(3)) u_dut3 (
        .i_aclk(aclk), .i_areset(areset),
        .i_s_ker_tdata(ker_data), .i_s_ker_tvalid(ker_valid_g[0]),
        .o_s_ker_tready(ker_ready_v[0]),
        .i_s_pix_tdata(pix_data), .i_s_pix_tvalid(pix_valid_g[0]),
        .o_s_pix_tready(pix_ready_v[0]), .i_s_pix_tlast(pix_last),
        .o_m_conv_tdata(conv_data_v[0]), .o_m_conv_tvalid(conv_valid_v[0]),
        .i_m_conv_tready(conv_ready),
        .i_s_res_tdata(res_data), .i_s_res_tvalid(res_valid_g[0]),
        .o_s_res_tready(res_ready_v[0]),
        .o_m_out_tdata(out_data_v[0]), .o_m_out_tvalid(out_valid_v[0]),
        .i_m_out_tready(out_ready), .o_m_out_tlast(out_last_v[0]),
        .o_busy(busy_v[0]), .o_frame_err(err_v[0])
    );

    cnn_conv_scheduler #(.IMG_W(4), .IMG_H(4)) u_dut4 (
        .i_aclk(aclk), .i_areset(areset),
        .i_s_ker_tdata(ker_data), .i_s_ker_tvalid(ker_valid_g[1]),
        .o_s_ker_tready(ker_ready_v[1]),
        .i_s_pix_tdata(pix_data), .i_s_pix_tvalid(pix_valid_g[1]),
        .o_s_pix_tready(pix_ready_v[1]), .i_s_pix_tlast(pix_last),
        .o_m_conv_tdata(conv_data_v[1]), .o_m_conv_tvalid(conv_valid_v[1]),
        .i_m_conv_tready(conv_ready),
        .i_s_res_tdata(res_data), .i_s_res_tvalid(res_valid_g[1]),
        .o_s_res_tready(res_ready_v[1]),
        .o_m_out_tdata(out_data_v[1]), .o_m_out_tvalid(out_valid_v[1]),
        .i_m_out_tready(out_ready), .o_m_out_tlast(out_last_v[1]),
        .o_busy(busy_v[1]), .o_frame_err(err_v[1])
    );

    int           total = 0;
    int           bad = 0;
    logic [143:0] exp_conv_q [$];
    logic [20:0]  exp_out_q [$];  // {result, tlast}
    logic [19:0]  res_q [$];
    logic [7:0]   frm_pix [$];
    int           frm_idx, frm_tlast, frm_win, frm_nwin;
    logic         pix_en;
    logic [71:0]  cur_ker [2];
    logic         stall_chk, hold_chk, prio_chk;
    logic [143:0] stall_snap;
    logic [71:0]  win2;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] eng(input logic [143:0] b);
        return b[143:124] ^ {4'h0, b[15:0]} ^ 20'h5A5A5;
    endfunction

    task automatic drive();
        pix_valid = pix_en && (frm_idx < frm_pix.size());
        pix_data  = pix_valid ? frm_pix[frm_idx] : 8'h00;
        pix_last  = pix_valid && (frm_idx == frm_tlast);
        res_valid = (res_q.size() != 0) && !areset;
        res_data  = (res_q.size() != 0) ? res_q[0] : 20'h0;
    endtask

    // One clock: observe handshakes at negedge, update stimulus after posedge
    task automatic step();
        logic c_hs, o_hs, p_hs, k_hs;
        logic [143:0] e;
        logic [20:0]  o;
        logic [19:0]  d;
        @(negedge aclk);
        c_hs = conv_valid && conv_ready;
        o_hs = out_valid && out_ready;
        p_hs = pix_valid && pix_ready;
        k_hs = ker_valid && ker_ready;
        if (stall_chk) begin
            chk("stall_pix_ready", pix_ready, 0);
            chk("stall_conv_hold", conv_data, stall_snap);
            chk("stall_conv_valid", conv_valid, 1);
        end
        if (hold_chk) chk("rst_pix_ready_hold", pix_ready, 0);
        if (prio_chk) begin
            chk("prio_pix_ready", pix_ready, 0);
            chk("prio_ker_ready", ker_ready, 1);
        end
        if (c_hs) begin
            chk("conv_expected", exp_conv_q.size() != 0, 1);
            if (exp_conv_q.size() != 0) begin
                e = exp_conv_q.pop_front();
                chk("conv_beat", conv_data, e);
                exp_out_q.push_back({eng(e), frm_win == frm_nwin - 1});
            end
            if (sel && frm_win == 1) win2 = conv_data[71:0];
            frm_win++;
            res_q.push_back(eng(conv_data));
        end
        if (o_hs) begin
            chk("out_expected", exp_out_q.size() != 0, 1);
            if (exp_out_q.size() != 0) begin
                o = exp_out_q.pop_front();
                chk("out_data", out_data, o[20:1]);
                chk("out_tlast", out_last, o[0]);
            end
            if (res_q.size() != 0) d = res_q.pop_front();
        end
        @(posedge aclk);
        #1;
        if (p_hs) frm_idx++;
        if (k_hs) ker_valid = 1'b0;
        drive();
    endtask

    task automatic start_frame(input int w, input int h, input int stp, input int tl,
                               input logic with_ker, input logic [71:0] kern);
        logic [71:0] win;
        frm_pix.delete();
        for (int i = 0; i < w * h; i++) frm_pix.push_back(8'((i + 1) * stp));
        frm_idx   = 0;
        frm_tlast = tl;
        frm_win   = 0;
        frm_nwin  = (w - 2) * (h - 2);
        if (with_ker) begin
            cur_ker[sel] = kern;
            ker_data     = kern;
            ker_valid    = 1'b1;
        end
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                win = '0;
                for (int k = 0; k < 9; k++) win = {win[63:0], frm_pix[(r - 2 + k / 3) * w + c - 2 + k % 3]};
                exp_conv_q.push_back({cur_ker[sel], win});
            end
        end
        pix_en = 1'b1;
        drive();
    endtask

    task automatic run_frame(input int stall_at);
        int   n = 0;
        logic stalled = 1'b0;
        while (!(frm_idx == frm_pix.size() && !busy && !ker_valid &&
                 exp_conv_q.size() == 0 && exp_out_q.size() == 0) && n < 300) begin
            if (stall_at >= 0 && !stalled && frm_idx >= stall_at && conv_valid) begin
                conv_ready = 1'b0;
                stall_snap = conv_data;
                stall_chk  = 1'b1;
                repeat (5) step();
                conv_ready = 1'b1;
                stall_chk  = 1'b0;
                stalled    = 1'b1;
            end
            step();
            n++;
        end
        chk("frame_complete", n < 300, 1);
        chk("frame_windows", frm_win, frm_nwin);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int n;
        areset = 1'b1; sel = 1'b0; ker_valid = 1'b0; ker_data = '0;
        conv_ready = 1'b1; out_ready = 1'b1; pix_en = 1'b0;
        stall_chk = 1'b0; hold_chk = 1'b0; prio_chk = 1'b0;
        frm_idx = 0; frm_tlast = -1; frm_win = 0; frm_nwin = 0; win2 = '0;
        cur_ker[0] = '0; cur_ker[1] = '0;
        drive();
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_ker_ready", ker_ready, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_conv_valid", conv_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        areset = 1'b0;
        #1;
        chk("idle_ker_ready", ker_ready, 1);
        chk("idle_pix_ready_unloaded", pix_ready, 0);

        // 3x3 frame with the reference kernel and pixels 10..90
        start_frame(3, 3, 10, 8, 1'b1, 72'h0100FF0100FF0100FF);
        exp_conv_q.delete();
        exp_conv_q.push_back(144'h0100FF0100FF0100FF0A141E28323C46505A);
        run_frame(-1);
        chk("f1_frame_err", frame_err, 0);

        // Second frame reuses the stored kernel
        start_frame(3, 3, 3, 8, 1'b0, '0);
        run_frame(-1);
        chk("f2_frame_err", frame_err, 0);

        // Early tlast on pixel 5: flag sets, frame still completes
        start_frame(3, 3, 7, 4, 1'b0, '0);
        run_frame(-1);
        chk("tlast_err_set", frame_err, 1);

        // Kernel and pixel together in IDLE: kernel first, pixel held, error cleared
        start_frame(3, 3, 11, 8, 1'b1, 72'h112233445566778899);
        prio_chk = 1'b1;
        step();
        prio_chk = 1'b0;
        chk("prio_err_cleared", frame_err, 0);
        chk("prio_pix_held", frm_idx, 0);
        chk("prio_busy", busy, 1);
        run_frame(-1);
        chk("f4_frame_err", frame_err, 0);

        // Reset after 6 pixels
        start_frame(3, 3, 9, 8, 1'b0, '0);
        n = 0;
        while (frm_idx < 6 && n < 50) begin
            step();
            n++;
        end
        chk("pre_reset_pixels", frm_idx, 6);
        pix_en = 1'b0;
        areset = 1'b1;
        exp_conv_q.delete();
        exp_out_q.delete();
        res_q.delete();
        drive();
        repeat (2) step();
        chk("mid_rst_ker_ready", ker_ready, 0);
        chk("mid_rst_pix_ready", pix_ready, 0);
        chk("mid_rst_conv_valid", conv_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        areset = 1'b0;
        cur_ker[0] = 72'hA1B2C3D4E5F6071829;
        start_frame(3, 3, 5, 8, 1'b0, '0);
        hold_chk = 1'b1;
        repeat (4) step();
        hold_chk = 1'b0;
        chk("post_rst_no_pixel", frm_idx, 0);
        chk("post_rst_ker_ready", ker_ready, 1);
        ker_data  = cur_ker[0];
        ker_valid = 1'b1;
        run_frame(-1);

        // 4x4 frame with engine backpressure mid-frame
        sel = 1'b1;
        #1;
        start_frame(4, 4, 1, 15, 1'b1, 72'h0102030405060708F0);
        run_frame(6);
        chk("win2_img", win2, 72'h0203040607080A0B0C);
        chk("f6_frame_err", frame_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_conv_scheduler.md
# cnn_conv_scheduler

Frame-level sequencer for the 3x3 convolution engine `CNN_DVCON`. It accepts one 3x3 kernel and a raster-scanned 8-bit image, buffers two image lines, and builds every valid 3x3 window. Each window is issued to the engine as one 144-bit AXI-Stream beat (kernel‖window). The 20-bit engine results are forwarded to the output stream, with `tlast` asserted on the last result of the frame. It sits between the SoC-side DMA streams and the engine.

## Interface
- `IMG_W`, default 8: frame width in pixels, minimum 3.
- `IMG_H`, default 8: frame height in pixels, minimum 3.
- `aclk` in 1: clock. Everything is on the rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_ker_tdata` in 72, `s_ker_tvalid` in 1, `s_ker_tready` out 1: kernel beat. Bits [71:64] are ker0 and bits [7:0] are ker8, in row-major order.
- `s_pix_tdata` in 8, `s_pix_tvalid` in 1, `s_pix_tready` out 1, `s_pix_tlast` in 1: pixel stream in raster order. `tlast` marks the final pixel of the frame.
- `m_conv_tdata` out 144, `m_conv_tvalid` out 1, `m_conv_tready` in 1: beat to the engine, laid out MSB first as {ker0..ker8, img0..img8}.
- `s_res_tdata` in 20, `s_res_tvalid` in 1, `s_res_tready` out 1: result stream from the engine.
- `m_out_tdata` out 20, `m_out_tvalid` out 1, `m_out_tready` in 1, `m_out_tlast` out 1: result stream to the SoC.
- `busy` out 1: high when the FSM is not in IDLE.
- `frame_err` out 1: sticky flag for a `tlast` mismatch.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `s_ker_tready`=1.
  - `s_pix_tready`=`kernel_loaded`.
  - A kernel beat is latched into the kernel register. It sets `kernel_loaded`, clears `frame_err`, and moves the FSM to RUN.
  - If no kernel beat is present and `kernel_loaded`=1, the first pixel is accepted with the stored kernel, and the FSM moves to RUN.
  - If both streams are valid in the same cycle, only the kernel beat is accepted; `s_pix_tready` is 0 that cycle.
- **RUN:**
  - `s_ker_tready`=0.
  - Each accepted pixel at (row r, col c) shifts into the 3x3 window register and the line buffers (two arrays of `IMG_W`x8).
  - When r≥2 and c≥2, a window beat is registered:
    - img0..2 are row r-2, cols c-2..c.
    - img3..5 are row r-1, cols c-2..c.
    - img6..8 are row r, cols c-2..c.
  - When the last pixel (index `IMG_W`·`IMG_H`-1) is accepted, the FSM moves to DRAIN.
- **DRAIN:**
  - Pixels are not accepted.
  - When the final result beat is accepted on `m_out`, the FSM returns to IDLE with the kernel retained.
- **Result path:** combinational pass-through.
  - `m_out_tdata`=`s_res_tdata`, `m_out_tvalid`=`s_res_tvalid`, `s_res_tready`=`m_out_tready`.
  - These are gated by FSM≠IDLE; in IDLE `s_res_tready`=0 and `m_out_tvalid`=0.
  - A result counter counts to N=(`IMG_W`-2)(`IMG_H`-2). `m_out_tlast`=1 when the count is N-1.
- **`tlast` checking:** `frame_err` sets if `s_pix_tlast` disagrees with the last-pixel position, in either direction. Pixel counting is unaffected and frame length is always `IMG_W`·`IMG_H`.
- **Arithmetic:** none on data. The result width of 20 bits is unchanged by this block.

## Timing
- **Reset values:**
  - All `tvalid` outputs 0, `m_out_tlast` 0.
  - `s_ker_tready` 0 while `areset` is high, then 1 in IDLE.
  - `s_pix_tready` 0, `busy` 0, `frame_err` 0.
  - `kernel_loaded` 0, all counters 0.
- **Window issue latency:** `m_conv_tvalid` rises 1 cycle after the pixel that completes the window is accepted.
- **Window hold:** `m_conv_tdata` is held stable while `m_conv_tvalid`=1 and `m_conv_tready`=0.
- **Pixel backpressure:** `s_pix_tready` = RUN && (!`m_conv_tvalid` || `m_conv_tready`). When it is high, throughput is 1 pixel per cycle.
- **Column wrap:** the column counter wraps at `IMG_W`-1 and the row counter increments. Windows are never formed across a row boundary.
- **Reset mid-frame:** all state returns to reset values, in-flight windows are dropped, and the kernel must be reloaded. The top level ties the engine's `aresetn` to ~`areset`.

## Structure
- **Package `cnn_pkg`:**
  - `PIX_W`=8, `KER_TAPS`=9, `RES_W`=20.
  - Conv beat width 144.
  - FSM state enum.
- **Sub-module `cnn_line_window`:** holds the two line buffers, the 3x3 shift window and the row/column counters. It outputs the window and a `win_valid` strobe.
- **Top level:** contains the FSM, kernel register, output register, result counter and `tlast` checking.

## Test plan
- **3x3 frame:** set `IMG_W`=`IMG_H`=3. Send kernel {01,00,FF,01,00,FF,01,00,FF}, then pixels 10,20,…,90. Expect exactly one `m_conv` beat equal to {01,00,FF,01,00,FF,01,00,FF,0A,14,1E,28,32,3C,46,50,5A}. The engine's result appears on `m_out` with `tlast`=1, and the FSM returns to IDLE.
- **4x4 frame:** pixels 1..16 produce 4 windows in order. The second window's img fields are 2,3,4,6,7,8,10,11,12. `m_out_tlast` is set on the 4th result only.
- **Backpressure:** hold `m_conv_tready`=0 for 5 cycles in mid-frame. `s_pix_tready` stays 0 and `m_conv_tdata` stays constant. No window is lost or duplicated.
- **Kernel reuse and priority:**
  - After frame 1, a second frame with no kernel beat uses the stored kernel.
  - Kernel and pixel valid in the same IDLE cycle: the kernel is taken and the pixel is held.
- **`tlast` errors:** `s_pix_tlast` asserted on pixel 5 of a 9-pixel frame sets `frame_err`. The frame still completes with 1 window, and the next kernel load clears `frame_err`.
- **Reset mid-frame:** assert `areset` after 6 pixels. All outputs return to reset values and `s_pix_tready` stays 0 until a new kernel is accepted.
